uartrx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Line format: 8N1, idle-high line, one start bit (low), DATA_BITS data bits LSB first, one stop bit (high), CLKS_PER_BIT clocks per bit.
- Samples each bit at mid-bit and delivers each byte on a valid/ready output port with a one-entry holding register.
- Flags framing errors and overruns as single-cycle pulses.

---
 rtl/uartrx_if.sv | 35 +++
 rtl/uartrx.sv | 159 +++++++++++++++
 tb/tb_uartrx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uartrx_if.sv
// Byte-stream port of the UART receiver: serial line and consumer handshake in,
// received byte, valid and status pulses out.
interface uartrx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 ready;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    // Receiver side
    modport slave (
        input  rx,
        input  ready,
        output data,
        output valid,
        output frame_err,
        output overrun,
        output busy
    );

    // Line driver / byte consumer side
    modport master (
        output rx,
        output ready,
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uartrx.sv
// UART receiver: LSB-first N1 frames, mid-bit sampling, one-entry holding
// register on a valid/ready port, single-cycle framing-error and overrun pulses.
module uartrx #(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8
) (
    input  logic     clk,
    input  logic     rst,
    uartrx_if.slave  bus
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CTR_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CTR_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic                 rxMeta_q;
    logic                 rxSync_q;
    state_t               state_q;
    logic [CW-1:0]        ctr_q;
    logic [CW-1:0]        ctr_d;
    logic [BW-1:0]        bitIdx_q;
    logic [BW-1:0]        bitIdx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frameErr_q;
    logic                 overrun_q;
    logic                 busy_q;

    // Two-flop synchronizer; resets to the idle-high line level so release never fakes a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= bus.rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Next values for the bit-period counter, bit index and the right-shifting data register
    always_comb begin
        ctr_d    = ctr_q + 1'b1;
        bitIdx_d = bitIdx_q + 1'b1;
        shift_d  = shift_q >> 1;
        shift_d[DATA_BITS-1] = rxSync_q;
    end

    // Frame FSM plus holding register; status pulses default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;

            if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        state_q <= START;
                        ctr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (ctr_q == CTR_HALF) begin
                        if (!rxSync_q) begin
                            state_q  <= DATA;
                            ctr_q    <= '0;
                            bitIdx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        ctr_q <= ctr_d;
                    end
                end

                DATA: begin
                    if (ctr_q == CTR_LAST) begin
                        shift_q  <= shift_d;
                        ctr_q    <= '0;
                        bitIdx_q <= bitIdx_d;
                        if (bitIdx_q == BIT_LAST) begin
                            state_q <= STOP;
                        end
                    end else begin
                        ctr_q <= ctr_d;
                    end
                end

                STOP: begin
                    if (ctr_q == CTR_LAST) begin
                        ctr_q <= '0;
                        if (rxSync_q) begin
                            if (!valid_q || bus.ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= BREAK;
                        end
                    end else begin
                        ctr_q <= ctr_d;
                    end
                end

                BREAK: begin
                    if (rxSync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frameErr_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uartrx.sv
// Scoreboard bench for uartrx: directed frames push expected events, a negedge
// monitor pops and compares whenever the receiver presents a byte or a pulse.
module tb_uartrx;
    localparam int CPB = 50;
    localparam int DB  = 8;

    typedef enum int {
        EV_BYTE,
        EV_FERR,
        EV_OVR
    } evKind_t;

    typedef struct {
        evKind_t    kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    ev_t  expQ[$];
    int   nChecks = 0;
    int   nPass = 0;
    int   validCycles = 0;
    int   lastPresCycle = -1;
    int   frameStart = 0;
    logic prevValid = 1'b0;
    logic prevHs = 1'b0;
    logic newPres;

    uartrx_if #(.DATA_BITS(DB)) bus();

    uartrx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock and cycle counter used for latency measurement
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard time limit so a stuck run still ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run still active at time limit, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    task automatic pushExp(input evKind_t kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input evKind_t kind, input logic [7:0] data);
        ev_t e;
        if (expQ.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected event: got %s data 0x%0h, required none", kind.name(), data);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("event kind (%s)", kind.name()), int'(kind), int'(e.kind));
            if (kind == EV_BYTE && e.kind == EV_BYTE) checkOutput("byte data", data, e.data);
        end
    endtask

    // Monitor: a byte is newly presented when valid rises or is refilled right after a handshake
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
            prevHs    = 1'b0;
        end else begin
            newPres = bus.valid && (!prevValid || prevHs);
            if (newPres) begin
                lastPresCycle = cyc;
                popCheck(EV_BYTE, bus.data);
            end
            if (bus.frame_err) popCheck(EV_FERR, 8'h00);
            if (bus.overrun)   popCheck(EV_OVR, 8'h00);
            if (bus.valid) validCycles++;
            prevValid = bus.valid;
            prevHs    = bus.valid && bus.ready;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; stopLowBits > 0 holds the stop bit low that many bit times first
    task automatic applyStimulus(input logic [7:0] b, input int stopLowBits);
        frameStart = cyc;
        bus.rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < DB; i++) begin
            bus.rx = b[i];
            waitCycles(CPB);
        end
        if (stopLowBits > 0) begin
            bus.rx = 1'b0;
            waitCycles(stopLowBits * CPB);
        end
        bus.rx = 1'b1;
        waitCycles(CPB);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid"},     bus.valid, 0);
        checkOutput({tag, " data"},      bus.data, 0);
        checkOutput({tag, " frame_err"}, bus.frame_err, 0);
        checkOutput({tag, " overrun"},   bus.overrun, 0);
        checkOutput({tag, " busy"},      bus.busy, 0);
    endtask

    initial begin
        int vc0;
        bus.rx    = 1'b1;
        bus.ready = 1'b0;
        #1 rst = 1'b1;
        #1 checkAllZero("reset");
        waitCycles(3);
        rst = 1'b0;
        waitCycles(5);

        // Clean 0xA5 with consumer always ready
        bus.ready = 1'b1;
        vc0 = validCycles;
        pushExp(EV_BYTE, 8'hA5);
        applyStimulus(8'hA5, 0);
        checkOutput("A5 latency from drive", lastPresCycle - frameStart, 478);
        checkOutput("A5 valid width", validCycles - vc0, 1);
        checkOutput("A5 busy after frame", bus.busy, 0);

        // 10-cycle low glitch rejected, then 0x3C
        bus.rx = 1'b0;
        waitCycles(10);
        bus.rx = 1'b1;
        waitCycles(30);
        checkOutput("glitch busy", bus.busy, 0);
        pushExp(EV_BYTE, 8'h3C);
        applyStimulus(8'h3C, 0);

        // 0x55 with stop held low for two bit times, then 0x81
        vc0 = validCycles;
        pushExp(EV_FERR, 8'h00);
        fork
            applyStimulus(8'h55, 2);
            begin
                waitCycles(540);
                checkOutput("break busy", bus.busy, 1);
            end
        join
        checkOutput("break valid stays low", validCycles - vc0, 0);
        checkOutput("break busy released", bus.busy, 0);
        pushExp(EV_BYTE, 8'h81);
        applyStimulus(8'h81, 0);

        // Overrun: 0x12 then 0x34 with consumer stalled
        bus.ready = 1'b0;
        pushExp(EV_BYTE, 8'h12);
        applyStimulus(8'h12, 0);
        pushExp(EV_OVR, 8'h00);
        applyStimulus(8'h34, 0);
        checkOutput("overrun valid held", bus.valid, 1);
        checkOutput("overrun data kept", bus.data, 8'h12);
        bus.ready = 1'b1;
        @(negedge clk);
        checkOutput("valid before accept", bus.valid, 1);
        @(negedge clk);
        checkOutput("valid after accept", bus.valid, 0);
        waitCycles(1);

        // Ready asserted exactly on the completion cycle of 0x34 with 0x12 pending
        bus.ready = 1'b0;
        pushExp(EV_BYTE, 8'h12);
        applyStimulus(8'h12, 0);
        pushExp(EV_BYTE, 8'h34);
        fork
            applyStimulus(8'h34, 0);
            begin
                waitCycles(477);
                bus.ready = 1'b1;
                waitCycles(1);
                bus.ready = 1'b0;
            end
        join
        checkOutput("swap valid", bus.valid, 1);
        checkOutput("swap data", bus.data, 8'h34);
        bus.ready = 1'b1;
        waitCycles(3);
        checkOutput("swap drained", bus.valid, 0);

        // Reset mid-frame of 0xFF, then clean 0x5A
        fork
            applyStimulus(8'hFF, 0);
            begin
                waitCycles(200);
                rst = 1'b1;
                #1 checkAllZero("mid-frame reset");
                waitCycles(3);
                rst = 1'b0;
            end
        join
        waitCycles(20);
        checkOutput("post-reset busy", bus.busy, 0);
        pushExp(EV_BYTE, 8'h5A);
        applyStimulus(8'h5A, 0);

        waitCycles(50);
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
